// File: rtl/mac_operand_feeder.sv
// Operand feeder for mac_array: buffers A/B beats in a FIFO and, per job command,
// emits a num_valid strobe followed by exactly K gapless beats (zeros otherwise).
module mac_operand_feeder #(
  parameter int MULER_WIDTH = 8,
  parameter int NUM_WIDTH   = 16,
  parameter int ROW_SIZE    = 8,
  parameter int COLUMN_SIZE = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int GAP_CYCLES  = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic [NUM_WIDTH-1:0]               cmd_num,
  input  logic                               op_valid,
  output logic                               op_ready,
  input  logic [ROW_SIZE*MULER_WIDTH-1:0]    op_a,
  input  logic [COLUMN_SIZE*MULER_WIDTH-1:0] op_b,
  output logic                               num_valid,
  output logic [NUM_WIDTH-1:0]               num,
  output logic [ROW_SIZE*MULER_WIDTH-1:0]    data_a,
  output logic [COLUMN_SIZE*MULER_WIDTH-1:0] data_b,
  output logic                               busy,
  output logic                               done,
  output logic                               err_cmd
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int A_W   = ROW_SIZE * MULER_WIDTH;
  localparam int B_W   = COLUMN_SIZE * MULER_WIDTH;
  localparam int GW    = $clog2(GAP_CYCLES + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ISSUE,
    S_STREAM,
    S_GAP
  } state_t;

  state_t state, state_nx;

  logic [A_W-1:0]       mem_a [FIFO_DEPTH];
  logic [B_W-1:0]       mem_b [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  logic [NUM_WIDTH-1:0] k_q;
  logic [NUM_WIDTH-1:0] rem;
  logic [GW-1:0]        gap_cnt;
  logic                 push, pop, cmd_fire, cmd_bad;

  assign op_ready  = !rst && (count < (AW+1)'(FIFO_DEPTH));
  assign cmd_ready = !rst && (state == S_IDLE);
  assign push      = op_valid && op_ready;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign cmd_bad   = (cmd_num == '0) || (cmd_num > NUM_WIDTH'(FIFO_DEPTH));
  assign busy      = (state != S_IDLE);
  // A beat leaves the FIFO on every edge that lands in STREAM, so the popped
  // entry is registered straight onto data_a/data_b for that cycle.
  assign pop       = (state_nx == S_STREAM);

  // NOTE: state_nx takes its default before the case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:   if (cmd_fire && !cmd_bad) state_nx = S_WAIT;
      S_WAIT:   if (NUM_WIDTH'(count) >= k_q) state_nx = S_ISSUE;
      S_ISSUE:  state_nx = S_STREAM;
      S_STREAM: if (rem == NUM_WIDTH'(1)) state_nx = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
      S_GAP:    if (gap_cnt == GW'(GAP_CYCLES - 1)) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // NOTE: FIFO storage is not reset; pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= op_a;
      mem_b[wr_ptr] <= op_b;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      k_q       <= '0;
      rem       <= '0;
      gap_cnt   <= '0;
      num_valid <= 1'b0;
      num       <= '0;
      data_a    <= '0;
      data_b    <= '0;
      done      <= 1'b0;
      err_cmd   <= 1'b0;
    end else begin
      state <= state_nx;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase

      if (cmd_fire && !cmd_bad) k_q <= cmd_num;
      if (state == S_ISSUE)       rem <= k_q;
      else if (state == S_STREAM) rem <= rem - NUM_WIDTH'(1);
      if (state == S_STREAM)      gap_cnt <= '0;
      else if (state == S_GAP)    gap_cnt <= gap_cnt + GW'(1);

      // Outputs are registered from the next state so they line up with the state they belong to.
      num_valid <= (state_nx == S_ISSUE);
      num       <= (state_nx == S_ISSUE) ? k_q : '0;
      data_a    <= pop ? mem_a[rd_ptr] : '0;
      data_b    <= pop ? mem_b[rd_ptr] : '0;
      done      <= (state == S_STREAM) && (rem == NUM_WIDTH'(1));
      err_cmd   <= cmd_fire && cmd_bad;
    end
  end

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Directed bench for mac_operand_feeder: one instance with GAP_CYCLES=0 and one
// with GAP_CYCLES=3, selected onto a shared set of observed signals.
module tb_mac_operand_feeder;
  localparam int NW = 16;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst = 1'b1, g_rst = 1'b1, sel = 1'b0;
  logic cmd_valid = 1'b0;
  logic [NW-1:0] cmd_num = '0;
  logic op_valid = 1'b0;
  logic [DW-1:0] op_a = '0, op_b = '0;

  logic m_cmd_ready, m_op_ready, m_num_valid, m_busy, m_done, m_err_cmd;
  logic g_cmd_ready, g_op_ready, g_num_valid, g_busy, g_done, g_err_cmd;
  logic s_cmd_ready, s_op_ready, s_num_valid, s_busy, s_done, s_err_cmd;
  logic [NW-1:0] m_num, g_num, s_num;
  logic [DW-1:0] m_data_a, m_data_b, g_data_a, g_data_b, s_data_a, s_data_b;

  mac_operand_feeder #(.GAP_CYCLES(0)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(m_cmd_ready), .cmd_num(cmd_num),
    .op_valid(op_valid), .op_ready(m_op_ready), .op_a(op_a), .op_b(op_b),
    .num_valid(m_num_valid), .num(m_num), .data_a(m_data_a), .data_b(m_data_b),
    .busy(m_busy), .done(m_done), .err_cmd(m_err_cmd)
  );

  mac_operand_feeder #(.GAP_CYCLES(3)) dut_gap (
    .clk(clk), .rst(g_rst), .cmd_valid(cmd_valid), .cmd_ready(g_cmd_ready), .cmd_num(cmd_num),
    .op_valid(op_valid), .op_ready(g_op_ready), .op_a(op_a), .op_b(op_b),
    .num_valid(g_num_valid), .num(g_num), .data_a(g_data_a), .data_b(g_data_b),
    .busy(g_busy), .done(g_done), .err_cmd(g_err_cmd)
  );

  assign s_cmd_ready = sel ? g_cmd_ready : m_cmd_ready;
  assign s_op_ready  = sel ? g_op_ready  : m_op_ready;
  assign s_num_valid = sel ? g_num_valid : m_num_valid;
  assign s_num       = sel ? g_num       : m_num;
  assign s_data_a    = sel ? g_data_a    : m_data_a;
  assign s_data_b    = sel ? g_data_b    : m_data_b;
  assign s_busy      = sel ? g_busy      : m_busy;
  assign s_done      = sel ? g_done      : m_done;
  assign s_err_cmd   = sel ? g_err_cmd   : m_err_cmd;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  int issue_cyc = 0, last_beat_cyc = 0;
  logic [2*DW-1:0] mq [$];

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_a(input int k);
    logic [7:0] v;
    v = k[7:0];
    return {8{v}};
  endfunction

  function automatic logic [DW-1:0] mk_b(input int k);
    return 64'h1 << (8 * (k % 8));
  endfunction

  // Holds a beat on the bus from a falling edge until the rising edge that accepts it.
  task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int n = 0;
    @(negedge clk);
    op_valid = 1'b1; op_a = a; op_b = b;
    while (!s_op_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n == 200) check("push_timeout", 1'b0, 1'b1);
    else begin
      @(posedge clk);
      mq.push_back({a, b});
    end
    #1 op_valid = 1'b0;
  endtask

  task automatic send_cmd(input int k, output int waited);
    waited = 0;
    cmd_valid = 1'b1; cmd_num = NW'(k);
    while (!s_cmd_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited == 50) check("cmd_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic expect_stream(input int k, output int waited);
    logic [2*DW-1:0] exp;
    waited = 0;
    while (!s_num_valid && waited < 100) begin
      check("idle_data", s_data_a | s_data_b, '0);
      @(negedge clk);
      waited++;
    end
    if (waited == 100) begin
      check("issue_timeout", 1'b0, 1'b1);
      return;
    end
    issue_cyc = cyc;
    check("num", s_num, DW'(k));
    check("issue_data", s_data_a | s_data_b, '0);
    check("issue_buffered", mq.size() >= k, 1'b1);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      exp = mq.pop_front();
      check("beat_a", s_data_a, exp[2*DW-1:DW]);
      check("beat_b", s_data_b, exp[DW-1:0]);
      check("beat_nv", s_num_valid, 1'b0);
      check("beat_done", s_done, 1'b0);
    end
    last_beat_cyc = cyc;
    @(negedge clk);
    check("done", s_done, 1'b1);
    check("done_data", s_data_a | s_data_b, '0);
    check("done_nv", s_num_valid, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int w1, w2, lb, n;
    int bad_k [2];
    logic [2*DW-1:0] e;
    logic seen_nv;
    bad_k = '{0, 17};

    // Reset release
    repeat (10) @(negedge clk);
    check("rst_cmd_ready", m_cmd_ready, 1'b0);
    check("rst_op_ready", m_op_ready, 1'b0);
    check("rst_outs", {m_num_valid, m_busy, m_done, m_err_cmd}, '0);
    check("rst_data", m_data_a | m_data_b | DW'(m_num), '0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_cmd_ready", m_cmd_ready, 1'b1);
    check("rel_op_ready", m_op_ready, 1'b1);

    // Basic job, data first
    for (int k = 0; k < 10; k++) push(64'h0101010101010101, mk_b(k));
    send_cmd(10, w1);
    expect_stream(10, w2);
    @(negedge clk);
    check("post_done", s_done, 1'b0);
    check("post_busy", s_busy, 1'b0);
    check("post_data", s_data_a | s_data_b, '0);

    // Command before data, op_valid toggling
    fork
      begin
        send_cmd(7, w1);
        expect_stream(7, w2);
      end
      begin
        repeat (2) @(negedge clk);
        for (int k = 0; k < 7; k++) begin
          push(mk_a(k + 20), mk_b(k + 3));
          @(negedge clk);
        end
      end
    join
    @(negedge clk);

    // Rejected commands
    foreach (bad_k[i]) begin
      send_cmd(bad_k[i], w1);
      check("rej_err", s_err_cmd, 1'b1);
      check("rej_busy", s_busy, 1'b0);
      check("rej_nv", s_num_valid, 1'b0);
      @(negedge clk);
      check("rej_err_clr", s_err_cmd, 1'b0);
      check("rej_cmd_ready", s_cmd_ready, 1'b1);
      check("rej_nv2", s_num_valid, 1'b0);
    end

    // Fill, attempt overflow, then stream 32 beats over two jobs with wrap
    for (int k = 0; k < 16; k++) push(mk_a(k + 40), mk_b(k));
    @(negedge clk);
    check("full_op_ready", s_op_ready, 1'b0);
    op_valid = 1'b1; op_a = '1; op_b = '1;
    @(posedge clk);
    #1 op_valid = 1'b0;
    @(negedge clk);
    fork
      begin
        send_cmd(16, w1);
        expect_stream(16, w2);
      end
      for (int k = 0; k < 16; k++) push(mk_a(k + 60), mk_b(k + 1));
    join
    @(negedge clk);
    send_cmd(16, w1);
    expect_stream(16, w2);
    check("drained_op_ready", s_op_ready, 1'b1);

    // Back-to-back, command in the done cycle
    for (int k = 0; k < 4; k++) push(mk_a(k + 80), mk_b(k + 5));
    send_cmd(2, w1);
    expect_stream(2, w2);
    lb = last_beat_cyc;
    send_cmd(2, w1);
    check("b2b_cmd_wait", DW'(w1), DW'(0));
    expect_stream(2, w2);
    check("b2b_latency", DW'(issue_cyc - lb), DW'(3));

    // Switch to the GAP_CYCLES=3 instance
    @(negedge clk);
    rst = 1'b1; sel = 1'b1; g_rst = 1'b0;
    mq.delete();
    @(negedge clk);
    check("g_cmd_ready", s_cmd_ready, 1'b1);

    for (int k = 0; k < 4; k++) push(mk_a(k + 100), mk_b(k + 2));
    send_cmd(2, w1);
    expect_stream(2, w2);
    lb = last_beat_cyc;
    check("gap_busy", s_busy, 1'b1);
    send_cmd(2, w1);
    check("gap_cmd_wait", DW'(w1), DW'(3));
    expect_stream(2, w2);
    check("gap_latency", DW'(issue_cyc - lb), DW'(6));

    // Reset during STREAM
    repeat (4) @(negedge clk);
    for (int k = 0; k < 3; k++) push(mk_a(k + 120), mk_b(k + 4));
    send_cmd(3, w1);
    n = 0;
    while (!s_num_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("mid_issue", s_num_valid, 1'b1);
    @(negedge clk);
    e = mq.pop_front();
    check("mid_beat", s_data_a, e[2*DW-1:DW]);
    g_rst = 1'b1;
    @(negedge clk);
    check("mid_rst_data", s_data_a | s_data_b | DW'(s_num), '0);
    check("mid_rst_flags", {s_num_valid, s_busy, s_done, s_err_cmd, s_cmd_ready, s_op_ready}, '0);
    @(negedge clk);
    check("mid_rst_nodone", s_done, 1'b0);
    g_rst = 1'b0;
    mq.delete();
    @(negedge clk);
    check("mid_rel_op_ready", s_op_ready, 1'b1);
    check("mid_rel_cmd_ready", s_cmd_ready, 1'b1);
    send_cmd(1, w1);
    seen_nv = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen_nv = seen_nv | s_num_valid;
    end
    check("mid_discard", seen_nv, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
